// File: rtl/alu_issue_unit.sv
// Sequential issue unit for the combinational ALU. Requests are accepted over a valid/ready
// channel, held on the ALU for a settle time, and the captured results are returned over a response channel.
module alu_issue_unit #(
  parameter int WORDSIZE      = 64,
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WORDSIZE-1:0]    req_a,
  input  logic [WORDSIZE-1:0]    req_b,
  input  logic [2:0]             req_op,
  output logic [WORDSIZE-1:0]    alu_input_a,
  output logic [WORDSIZE-1:0]    alu_input_b,
  output logic [2:0]             alu_operation,
  input  logic [WORDSIZE-1:0]    alu_result,
  input  logic                   alu_overflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORDSIZE-1:0]    rsp_result,
  output logic                   rsp_overflow,
  output logic [COUNT_WIDTH-1:0] op_count,
  output logic [COUNT_WIDTH-1:0] overflow_count
);

  // The settle counter only has to hold SETTLE_CYCLES-1.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] settle_cnt;
  logic             accept, capture, rsp_done;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand, capture and statistics registers; counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_input_a    <= '0;
      alu_input_b    <= '0;
      alu_operation  <= '0;
      settle_cnt     <= '0;
      rsp_result     <= '0;
      rsp_overflow   <= 1'b0;
      op_count       <= '0;
      overflow_count <= '0;
    end else begin
      if (accept) begin
        alu_input_a   <= req_a;
        alu_input_b   <= req_b;
        alu_operation <= req_op;
        settle_cnt    <= SETTLE_LOAD;
      end
      if (state == SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - 1'b1;
      if (capture) begin
        rsp_result   <= alu_result;
        rsp_overflow <= alu_overflow;
      end
      if (rsp_done) begin
        if (op_count != '1)
          op_count <= op_count + COUNT_WIDTH'(1);
        if (rsp_overflow && overflow_count != '1)
          overflow_count <= overflow_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule
